// File: rtl/acc_cpu_mc.sv
// acc_cpu_mc: multi-cycle parametrised accumulator CPU (FETCH/DECODE/EXEC/MEM/HALT)
// Ports: clk_i/reset (sync, active-high); imem_addr_o/imem_data_i sync-ROM fetch;
// dmem_req_o/we_o/addr_o/wdata_o/rdata_i/ack_i req-ack data port; reg_acc_out,
// curr_pc, curr_ins expose ACC/PC/IR; halted_o flags the terminal HALT state.
module acc_cpu_mc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [ADDR_W+3:0] imem_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic [DATA_W-1:0] reg_acc_out,
    output logic [ADDR_W-1:0] curr_pc,
    output logic [ADDR_W+3:0] curr_ins,
    output logic              halted_o
);
    localparam logic [3:0] OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                           OP_AND = 4'h5, OP_OR = 4'h6, OP_XOR = 4'h7, OP_JMP = 4'h8,
                           OP_JZ = 4'h9, OP_JC = 4'hA, OP_LDI = 4'hB, OP_SHL = 4'hC,
                           OP_SHR = 4'hD, OP_HLT = 4'hF;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next, w_a;
    logic [DATA_W-1:0] r_acc, w_res, w_imm;
    logic [ADDR_W+3:0] r_ir;
    logic [DATA_W:0]   w_sum, w_diff;
    logic [3:0]        w_op;
    logic              r_z, r_c, w_cn, w_is_mem, w_wr_acc, w_done;

    assign w_op      = r_ir[ADDR_W+3:ADDR_W];
    assign w_a       = r_ir[ADDR_W-1:0];
    assign w_imm     = DATA_W'(w_a);
    assign w_sum     = {1'b0, r_acc} + {1'b0, dmem_rdata_i};
    // Bit DATA_W of the widened difference is the borrow, i.e. ACC < operand.
    assign w_diff    = {1'b0, r_acc} - {1'b0, dmem_rdata_i};
    assign w_is_mem  = (w_op >= OP_LDA) && (w_op <= OP_XOR);
    assign w_wr_acc  = (w_is_mem && w_op != OP_STA) || w_op == OP_LDI || w_op == OP_SHL || w_op == OP_SHR;
    assign w_done    = (r_state == S_EXEC && !w_is_mem && w_op != OP_HLT) || (r_state == S_MEM && dmem_ack_i);
    assign w_pc_next = (w_op == OP_JMP || (w_op == OP_JZ && r_z) || (w_op == OP_JC && r_c)) ? w_a : r_pc + 1'b1;

    // LDA/LDI fall through with w_cn = r_c, so C can be written on every ACC update.
    always_comb begin
        w_res = r_acc;
        w_cn  = r_c;
        case (w_op)
            OP_LDA: w_res = dmem_rdata_i;
            OP_ADD: {w_cn, w_res} = w_sum;
            OP_SUB: {w_cn, w_res} = w_diff;
            OP_AND: begin w_res = r_acc & dmem_rdata_i; w_cn = 1'b0; end
            OP_OR:  begin w_res = r_acc | dmem_rdata_i; w_cn = 1'b0; end
            OP_XOR: begin w_res = r_acc ^ dmem_rdata_i; w_cn = 1'b0; end
            OP_LDI: w_res = w_imm;
            OP_SHL: begin w_res = {r_acc[DATA_W-2:0], 1'b0}; w_cn = r_acc[DATA_W-1]; end
            OP_SHR: begin w_res = {1'b0, r_acc[DATA_W-1:1]}; w_cn = r_acc[0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_acc   <= '0;
            r_ir    <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_ir <= imem_data_i;
            if (w_done) begin
                r_pc <= w_pc_next;
                if (w_wr_acc) begin
                    r_acc <= w_res;
                    r_z   <= (w_res == '0);
                    r_c   <= w_cn;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = w_is_mem ? S_MEM : (w_op == OP_HLT ? S_HALT : S_FETCH);
            S_MEM:    w_next = dmem_ack_i ? S_FETCH : S_MEM;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        dmem_req_o = (r_state == S_MEM);
        dmem_we_o  = (r_state == S_MEM) && (w_op == OP_STA);
        halted_o   = (r_state == S_HALT);
    end

    assign imem_addr_o  = r_pc;
    assign dmem_addr_o  = w_a;
    assign dmem_wdata_o = r_acc;
    assign reg_acc_out  = r_acc;
    assign curr_pc      = r_pc;
    assign curr_ins     = r_ir;
endmodule

// File: tb/tb_acc_cpu_mc.sv
// tb_acc_cpu_mc: directed bench for acc_cpu_mc with a data-access scoreboard
module tb_acc_cpu_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, rst2 = 1'b1;
    logic [4:0] imem_addr, dmem_addr, pc;
    logic [8:0] rom_q, ins_r;
    logic       req, we, ack, halted, force_ack = 1'b0;
    logic [7:0] wdata, rdata, acc;
    logic [8:0] rom [32];
    logic [7:0] ram [32];
    int checks = 0, errors = 0, ram_writes = 0, req_cycles = 0, ack_delay = 0, wcnt = 0, n;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [4:0] pc;
    } acc_t;
    acc_t exp_q[$];

    acc_cpu_mc dut (
        .clk_i(clk), .reset(reset), .imem_addr_o(imem_addr), .imem_data_i(rom_q),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(wdata),
        .dmem_rdata_i(rdata), .dmem_ack_i(ack), .reg_acc_out(acc), .curr_pc(pc),
        .curr_ins(ins_r), .halted_o(halted)
    );

    assign ack   = force_ack | (req && wcnt >= ack_delay);
    assign rdata = ram[dmem_addr];

    always @(posedge clk) begin
        rom_q <= rom[imem_addr];
        wcnt  <= (req && !ack) ? wcnt + 1 : 0;
        if (req && ack && we) begin
            ram[dmem_addr] = wdata;
            ram_writes = ram_writes + 1;
        end
    end

    logic [7:0]  imem2_addr, daddr2, pc2;
    logic [11:0] rom2_q, ins2;
    logic        req2, we2, halted2;
    logic [15:0] wdata2, acc2;
    logic [11:0] rom2 [256];
    logic [15:0] ram2 [256];

    acc_cpu_mc #(.DATA_W(16), .ADDR_W(8)) dut2 (
        .clk_i(clk), .reset(rst2), .imem_addr_o(imem2_addr), .imem_data_i(rom2_q),
        .dmem_req_o(req2), .dmem_we_o(we2), .dmem_addr_o(daddr2), .dmem_wdata_o(wdata2),
        .dmem_rdata_i(ram2[daddr2]), .dmem_ack_i(req2), .reg_acc_out(acc2), .curr_pc(pc2),
        .curr_ins(ins2), .halted_o(halted2)
    );

    always @(posedge clk) begin
        rom2_q <= rom2[imem2_addr];
        if (req2 && we2) ram2[daddr2] = wdata2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every requested data access is checked against the head of the expected queue,
    // both while waiting (stability) and on the ack cycle (where it is retired).
    always @(negedge clk) begin
        if (!reset && req) begin
            req_cycles++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_access: observed addr 0x%0h we %0b expected none", dmem_addr, we);
            end else begin
                chk("acc_we", we, exp_q[0].we);
                chk("acc_addr", dmem_addr, exp_q[0].addr);
                chk("acc_pc", pc, exp_q[0].pc);
                if (exp_q[0].we) chk("acc_wdata", wdata, exp_q[0].wdata);
                if (ack) void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] a);
        return {op, a};
    endfunction

    function automatic acc_t ex(input logic w, input logic [4:0] a, input logic [7:0] d, input logic [4:0] p);
        return '{we: w, addr: a, wdata: d, pc: p};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            rom[i] = '0;
            ram[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_acc", acc, 0);
        chk("rst_ir", ins_r, 0);
        chk("rst_req", req, 0);
        chk("rst_we", we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_z", dut.r_z, 0);
        chk("rst_c", dut.r_c, 0);
        reset = 1'b0;
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic run_to_halt(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!halted && cnt < 500);
        chk("halt_reached", halted, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom2[i] = '0;
            ram2[i] = '0;
        end
        // LDI 5; ADD [3]; HLT with RAM[3]=0xFB
        clear_mem();
        rom[0] = ins(4'hB, 5);
        rom[1] = ins(4'h3, 3);
        rom[2] = ins(4'hF, 0);
        ram[3] = 8'hFB;
        exp_q.push_back(ex(0, 3, 0, 1));
        do_reset();
        run_to_halt(n);
        chk("t1_cycles", n, 10);
        chk("t1_acc", acc, 8'h00);
        chk("t1_z", dut.r_z, 1);
        chk("t1_c", dut.r_c, 1);
        chk("t1_pc", pc, 2);
        cyc(3);
        chk("t1_still_halted", halted, 1);
        chk("t1_pc_held", pc, 2);
        chk("t1_queue_empty", exp_q.size(), 0);

        // STA with ack delayed by 3 wait cycles
        clear_mem();
        rom[0] = ins(4'hB, 5'h0A);
        rom[1] = ins(4'h2, 7);
        rom[2] = ins(4'hF, 0);
        ack_delay = 3;
        exp_q.push_back(ex(1, 7, 8'h0A, 1));
        do_reset();
        req_cycles = 0;
        ram_writes = 0;
        run_to_halt(n);
        chk("t2_cycles", n, 13);
        chk("t2_req_cycles", req_cycles, 4);
        chk("t2_ram", ram[7], 8'h0A);
        chk("t2_writes", ram_writes, 1);
        chk("t2_pc", pc, 2);
        chk("t2_queue_empty", exp_q.size(), 0);
        ack_delay = 0;

        // JC not taken, LDI 0, JZ 0x1F taken, NOP at 0x1F wraps PC to 0
        clear_mem();
        rom[0]  = ins(4'hA, 4);
        rom[1]  = ins(4'hB, 0);
        rom[2]  = ins(4'h9, 5'h1F);
        rom[31] = ins(4'h0, 0);
        do_reset();
        cyc(3);
        chk("t3_jc_not_taken", pc, 1);
        cyc(3);
        chk("t3_ldi0_pc", pc, 2);
        chk("t3_ldi0_z", dut.r_z, 1);
        cyc(3);
        chk("t3_jz_taken", pc, 5'h1F);
        chk("t3_jz_ir", ins_r, 9'h13F);
        cyc(3);
        chk("t3_pc_wrap", pc, 0);

        // ALU / shift sequence with flags
        clear_mem();
        rom[0]  = ins(4'hB, 3);
        rom[1]  = ins(4'h4, 5);
        rom[2]  = ins(4'h1, 6);
        rom[3]  = ins(4'hC, 0);
        rom[4]  = ins(4'hB, 1);
        rom[5]  = ins(4'hD, 0);
        rom[6]  = ins(4'hA, 9);
        rom[9]  = ins(4'h5, 5);
        rom[10] = ins(4'h6, 5);
        rom[11] = ins(4'h7, 5);
        rom[12] = ins(4'hF, 0);
        ram[5] = 8'h05;
        ram[6] = 8'h81;
        exp_q.push_back(ex(0, 5, 0, 1));
        exp_q.push_back(ex(0, 6, 0, 2));
        exp_q.push_back(ex(0, 5, 0, 9));
        exp_q.push_back(ex(0, 5, 0, 10));
        exp_q.push_back(ex(0, 5, 0, 11));
        do_reset();
        cyc(3);
        chk("t4_ldi3", acc, 8'h03);
        cyc(4);
        chk("t4_sub_acc", acc, 8'hFE);
        chk("t4_sub_c", dut.r_c, 1);
        chk("t4_sub_z", dut.r_z, 0);
        cyc(4);
        chk("t4_lda_acc", acc, 8'h81);
        chk("t4_lda_c_kept", dut.r_c, 1);
        cyc(3);
        chk("t4_shl_acc", acc, 8'h02);
        chk("t4_shl_c", dut.r_c, 1);
        cyc(3);
        chk("t4_ldi1", acc, 8'h01);
        cyc(3);
        chk("t4_shr_acc", acc, 8'h00);
        chk("t4_shr_c", dut.r_c, 1);
        chk("t4_shr_z", dut.r_z, 1);
        cyc(3);
        chk("t4_jc_taken", pc, 9);
        cyc(4);
        chk("t4_and_acc", acc, 8'h00);
        chk("t4_and_c", dut.r_c, 0);
        chk("t4_and_z", dut.r_z, 1);
        cyc(4);
        chk("t4_or_acc", acc, 8'h05);
        chk("t4_or_z", dut.r_z, 0);
        cyc(4);
        chk("t4_xor_acc", acc, 8'h00);
        chk("t4_xor_z", dut.r_z, 1);
        run_to_halt(n);
        chk("t4_pc", pc, 12);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Reset while MEM is waiting for ack; late ack must be ignored
        clear_mem();
        rom[0] = ins(4'hB, 3);
        rom[1] = ins(4'h2, 2);
        rom[2] = ins(4'hF, 0);
        ack_delay = 100;
        exp_q.push_back(ex(1, 2, 8'h03, 1));
        do_reset();
        ram_writes = 0;
        cyc(8);
        chk("t5_req_waiting", req, 1);
        chk("t5_pc_not_advanced", pc, 1);
        do_reset();
        exp_q.delete();
        force_ack = 1'b1;
        cyc(1);
        force_ack = 1'b0;
        chk("t5_late_ack_pc", pc, 0);
        chk("t5_late_ack_acc", acc, 0);
        chk("t5_late_ack_req", req, 0);
        chk("t5_no_write", ram_writes, 0);
        ack_delay = 0;
        exp_q.push_back(ex(1, 2, 8'h03, 1));
        run_to_halt(n);
        chk("t5_restart_ram", ram[2], 8'h03);
        chk("t5_restart_writes", ram_writes, 1);
        chk("t5_queue_empty", exp_q.size(), 0);

        // DATA_W=16, ADDR_W=8 build: LDI 0xFF; ADD [0x80]=0xFF01; HLT
        rom2[0] = {4'hB, 8'hFF};
        rom2[1] = {4'h3, 8'h80};
        rom2[2] = {4'hF, 8'h00};
        ram2[8'h80] = 16'hFF01;
        rst2 = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!halted2 && n < 500);
        chk("t6_halted", halted2, 1);
        chk("t6_cycles", n, 10);
        chk("t6_acc", acc2, 16'h0000);
        chk("t6_c", dut2.r_c, 1);
        chk("t6_z", dut2.r_z, 1);
        chk("t6_pc", pc2, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
